// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller.
//   - Address split: tag[15:8] / index[7:5] / offset[4:0]
//   - Controller state enumeration and the metadata line layout
package cache_pkg;

  localparam int TAG_W           = 8;
  localparam int INDEX_W         = 3;
  localparam int OFFSET_W        = 5;
  localparam int DEPTH           = 8;
  localparam int WORDS_PER_BLOCK = 32;
  localparam int LINE_W          = 2 + TAG_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL,
    ACCESS
  } state_t;

  // Metadata entry: {valid, dirty, tag}
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } line_t;

endpackage

// File: rtl/cache_word_counter.sv
// Word offset counter for block transfers.
// Walks offsets 0..31, each offset split into two half-cycles (phase 0 = A,
// phase 1 = B).
//   clk, rst    : clock, synchronous active-high reset
//   clr         : restart at offset 0, phase A
//   en          : advance one half-cycle
//   count_inc   : offset of the half-cycle that follows the current one
//   phase_inc   : phase of the half-cycle that follows the current one
//   last        : current half-cycle is offset 31, phase B
module cache_word_counter
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  output logic [OFFSET_W-1:0] count_inc,
  output logic                phase_inc,
  output logic                last
);

  logic [OFFSET_W-1:0] count_q, count_d;
  logic                phase_q, phase_d;

  // Look-ahead values depend only on the flops, so the controller can use
  // them to build registered outputs without a combinational loop.
  always_comb begin
    phase_inc = ~phase_q;
    count_inc = phase_q ? count_q + 1'b1 : count_q;
    last      = (count_q == OFFSET_W'(WORDS_PER_BLOCK - 1)) && phase_q;
  end

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (clr) begin
      count_d = '0;
      phase_d = 1'b0;
    end else if (en) begin
      count_d = count_inc;
      phase_d = phase_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, 8-line, 32-byte-block, write-back / write-allocate cache
// controller. Only control is generated here; the SRAM/SDRAM datapath is
// external and steered by mux_sel / demux_sel.
//   clk, rst                : clock, synchronous active-high reset
//   Address_cpu, wr_rd_cpu  : CPU request (latched on acceptance)
//   DOut_cpu                : CPU write data, not used by control
//   cs_cpu / rdy_cpu        : request strobe / controller idle
//   Address_sdram, wr_rd_sdram, mstrb_sdram : SDRAM word access
//   mux_sel, demux_sel, wen_sram, address_cache_ctrl_sram : SRAM control
// All outputs are registered: the next-state logic computes the values for
// the upcoming cycle and they are captured on the same edge as the state.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       Address_cpu,
  input  logic [DATA_WIDTH-1:0]       DOut_cpu,
  input  logic                        wr_rd_cpu,
  input  logic                        cs_cpu,
  output logic                        rdy_cpu,
  output logic [ADDR_WIDTH-1:0]       Address_sdram,
  output logic                        wr_rd_sdram,
  output logic                        mstrb_sdram,
  output logic                        mux_sel,
  output logic                        demux_sel,
  output logic                        wen_sram,
  output logic [INDEX_W+OFFSET_W-1:0] address_cache_ctrl_sram
);

  logic [LINE_W-1:0] cache_line [0:DEPTH-1];

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic                        wr_q, wr_d;
  logic                        rdy_q, rdy_d;
  logic [ADDR_WIDTH-1:0]       sdram_addr_q, sdram_addr_d;
  logic                        sdram_wr_q, sdram_wr_d;
  logic                        mstrb_q, mstrb_d;
  logic                        mux_q, mux_d;
  logic                        demux_q, demux_d;
  logic                        wen_q, wen_d;
  logic [INDEX_W+OFFSET_W-1:0] sram_addr_q, sram_addr_d;

  logic                meta_we;
  logic [LINE_W-1:0]   meta_val;
  logic                cnt_clr, cnt_en, cnt_phase_inc, cnt_last;
  logic [OFFSET_W-1:0] cnt_count_inc;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  line_t               cur_line;

  // Write data travels on the external datapath only.
  logic unused_dout;
  assign unused_dout = ^DOut_cpu;

  assign req_tag  = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx  = addr_q[OFFSET_W +: INDEX_W];
  assign req_off  = addr_q[OFFSET_W-1:0];
  assign cur_line = line_t'(cache_line[req_idx]);

  cache_word_counter u_word_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .count_inc (cnt_count_inc),
    .phase_inc (cnt_phase_inc),
    .last      (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    rdy_d        = 1'b0;
    sdram_addr_d = '0;
    sdram_wr_d   = 1'b0;
    mstrb_d      = 1'b0;
    mux_d        = 1'b0;
    demux_d      = 1'b0;
    wen_d        = 1'b0;
    sram_addr_d  = '0;
    meta_we      = 1'b0;
    meta_val     = cache_line[req_idx];
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (cs_cpu) begin
          addr_d  = Address_cpu;
          wr_d    = wr_rd_cpu;
          rdy_d   = 1'b0;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (cur_line.valid && (cur_line.tag == req_tag)) begin
          state_d     = ACCESS;
          sram_addr_d = {req_idx, req_off};
          wen_d       = wr_q;
        end else if (cur_line.valid && cur_line.dirty) begin
          // Victim must reach SDRAM first; open with an SRAM read of word 0.
          state_d     = WRITEBACK;
          cnt_clr     = 1'b1;
          sram_addr_d = {req_idx, {OFFSET_W{1'b0}}};
          demux_d     = 1'b1;
        end else begin
          state_d      = FILL;
          cnt_clr      = 1'b1;
          sdram_addr_d = ADDR_WIDTH'({req_tag, req_idx, {OFFSET_W{1'b0}}});
          mstrb_d      = 1'b1;
        end
      end

      WRITEBACK: begin
        if (cnt_last) begin
          state_d      = FILL;
          cnt_clr      = 1'b1;
          sdram_addr_d = ADDR_WIDTH'({req_tag, req_idx, {OFFSET_W{1'b0}}});
          mstrb_d      = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (!cnt_phase_inc) begin
            sram_addr_d = {req_idx, cnt_count_inc};
            demux_d     = 1'b1;
          end else begin
            // Old tag is still in the metadata until the fill completes.
            sdram_addr_d = ADDR_WIDTH'({cur_line.tag, req_idx, cnt_count_inc});
            sdram_wr_d   = 1'b1;
            mstrb_d      = 1'b1;
          end
        end
      end

      FILL: begin
        if (cnt_last) begin
          state_d     = ACCESS;
          meta_we     = 1'b1;
          meta_val    = {1'b1, 1'b0, req_tag};
          sram_addr_d = {req_idx, req_off};
          wen_d       = wr_q;
        end else begin
          cnt_en = 1'b1;
          if (!cnt_phase_inc) begin
            sdram_addr_d = ADDR_WIDTH'({req_tag, req_idx, cnt_count_inc});
            mstrb_d      = 1'b1;
          end else begin
            sram_addr_d = {req_idx, cnt_count_inc};
            mux_d       = 1'b1;
            wen_d       = 1'b1;
          end
        end
      end

      ACCESS: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        if (wr_q) begin
          meta_we  = 1'b1;
          meta_val = {1'b1, 1'b1, cur_line.tag};
        end
      end

      default: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      rdy_q        <= 1'b1;
      sdram_addr_q <= '0;
      sdram_wr_q   <= 1'b0;
      mstrb_q      <= 1'b0;
      mux_q        <= 1'b0;
      demux_q      <= 1'b0;
      wen_q        <= 1'b0;
      sram_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      rdy_q        <= rdy_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_wr_q   <= sdram_wr_d;
      mstrb_q      <= mstrb_d;
      mux_q        <= mux_d;
      demux_q      <= demux_d;
      wen_q        <= wen_d;
      sram_addr_q  <= sram_addr_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_line
      always_ff @(posedge clk) begin
        if (rst) begin
          cache_line[gi] <= '0;
        end else if (meta_we && (req_idx == INDEX_W'(gi))) begin
          cache_line[gi] <= meta_val;
        end
      end
    end
  endgenerate

  assign rdy_cpu                 = rdy_q;
  assign Address_sdram           = sdram_addr_q;
  assign wr_rd_sdram             = sdram_wr_q;
  assign mstrb_sdram             = mstrb_q;
  assign mux_sel                 = mux_q;
  assign demux_sel               = demux_q;
  assign wen_sram                = wen_q;
  assign address_cache_ctrl_sram = sram_addr_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: miss/fill, dirty write-back, read hit
// and reset abandoning a fill. SDRAM strobes are logged on the falling edge.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Address_cpu = '0;
  logic [7:0]  DOut_cpu = 8'hA5;
  logic        wr_rd_cpu = 1'b0;
  logic        cs_cpu = 1'b0;
  logic        rdy_cpu;
  logic [15:0] Address_sdram;
  logic        wr_rd_sdram;
  logic        mstrb_sdram;
  logic        mux_sel;
  logic        demux_sel;
  logic        wen_sram;
  logic [7:0]  address_cache_ctrl_sram;

  int total = 0;
  int bad   = 0;

  logic [16:0] txn_q [$];
  int          fill_wr_cnt = 0;
  int          wb_rd_cnt   = 0;
  int          overlap_cnt = 0;

  int          lat;
  logic [7:0]  last_sram;
  logic [2:0]  last_flags;

  cache_controller dut (
    .clk                     (clk),
    .rst                     (rst),
    .Address_cpu             (Address_cpu),
    .DOut_cpu                (DOut_cpu),
    .wr_rd_cpu               (wr_rd_cpu),
    .cs_cpu                  (cs_cpu),
    .rdy_cpu                 (rdy_cpu),
    .Address_sdram           (Address_sdram),
    .wr_rd_sdram             (wr_rd_sdram),
    .mstrb_sdram             (mstrb_sdram),
    .mux_sel                 (mux_sel),
    .demux_sel               (demux_sel),
    .wen_sram                (wen_sram),
    .address_cache_ctrl_sram (address_cache_ctrl_sram)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mstrb_sdram) txn_q.push_back({wr_rd_sdram, Address_sdram});
    if (wen_sram && mux_sel) fill_wr_cnt++;
    if (demux_sel && !mstrb_sdram) wb_rd_cnt++;
    if (mstrb_sdram && wen_sram) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {rdy_cpu, wr_rd_sdram, mstrb_sdram, mux_sel, demux_sel, wen_sram},
          32'h20);
    check({tag, "_sdram_addr"}, Address_sdram, 32'h0);
    check({tag, "_sram_addr"}, address_cache_ctrl_sram, 32'h0);
  endtask

  task automatic check_lines(input string tag, input logic [9:0] exp7);
    for (int i = 0; i < 7; i++) check($sformatf("%s_line%0d", tag, i), dut.cache_line[i], 32'h0);
    check({tag, "_line7"}, dut.cache_line[7], exp7);
  endtask

  // Issue one request with cs held 'hold' cycles after acceptance; CPU inputs
  // are scrambled when cs drops. Counts cycles with rdy_cpu low and captures
  // the SRAM controls of the final busy cycle (the ACCESS cycle).
  task automatic run_req(input logic [15:0] addr, input logic wr, input int hold);
    @(negedge clk);
    txn_q.delete();
    fill_wr_cnt = 0;
    wb_rd_cnt   = 0;
    Address_cpu = addr;
    wr_rd_cpu   = wr;
    cs_cpu      = 1'b1;
    lat = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c + 1 >= hold) begin
        cs_cpu      = 1'b0;
        Address_cpu = 16'h1234;
        wr_rd_cpu   = ~wr;
      end
      if (rdy_cpu) break;
      lat++;
      last_sram  = address_cache_ctrl_sram;
      last_flags = {mux_sel, demux_sel, wen_sram};
    end
    $display("txn addr=%h wr=%0d latency=%0d sdram_strobes=%0d", addr, wr, lat, txn_q.size());
  endtask

  initial begin
    // Reset state
    pulse_reset();
    check_idle("reset");
    check_lines("reset", 10'h000);

    // Write miss to empty line 7
    run_req(16'hFFE0, 1'b1, 4);
    check("wm_latency", lat, 66);
    check("wm_strobes", txn_q.size(), 32);
    for (int k = 0; k < 32; k++)
      if (k < txn_q.size()) check($sformatf("wm_rd%0d", k), txn_q[k], {1'b0, 16'hFFE0 + 16'(k)});
    check("wm_fill_wr", fill_wr_cnt, 32);
    check("wm_access_addr", last_sram, 8'hE0);
    check("wm_access_flags", last_flags, 3'b001);
    check_lines("wm", 10'h3FF);

    // Dirty write miss: write-back of tag FF then fill of tag 9F
    run_req(16'h9FE2, 1'b1, 1);
    check("dwm_latency", lat, 130);
    check("dwm_strobes", txn_q.size(), 64);
    for (int k = 0; k < 64; k++)
      if (k < txn_q.size())
        check($sformatf("dwm_txn%0d", k), txn_q[k],
              (k < 32) ? {1'b1, 16'hFFE0 + 16'(k)} : {1'b0, 16'h9FE0 + 16'(k - 32)});
    check("dwm_wb_rd", wb_rd_cnt, 32);
    check("dwm_access_addr", last_sram, 8'hE2);
    check_lines("dwm", 10'h39F);

    // Dirty read miss, starting again from the first scenario
    pulse_reset();
    run_req(16'hFFE0, 1'b1, 4);
    check("rm_setup_line7", dut.cache_line[7], 10'h3FF);
    run_req(16'h9FE2, 1'b0, 1);
    check("drm_latency", lat, 130);
    check("drm_strobes", txn_q.size(), 64);
    if (txn_q.size() == 64) begin
      check("drm_first_wb", txn_q[0], {1'b1, 16'hFFE0});
      check("drm_last_wb", txn_q[31], {1'b1, 16'hFFFF});
      check("drm_first_fill", txn_q[32], {1'b0, 16'h9FE0});
      check("drm_last_fill", txn_q[63], {1'b0, 16'h9FFF});
    end
    check("drm_access_flags", last_flags, 3'b000);
    check_lines("drm", 10'h29F);

    // Read hit
    run_req(16'h9FE5, 1'b0, 1);
    check("hit_latency", lat, 2);
    check("hit_strobes", txn_q.size(), 0);
    check("hit_access_addr", last_sram, 8'hE5);
    check("hit_access_flags", last_flags, 3'b000);
    check_lines("hit", 10'h29F);

    // Reset in the middle of a clean fill of line 0
    @(negedge clk);
    Address_cpu = 16'h1200;
    wr_rd_cpu   = 1'b0;
    cs_cpu      = 1'b1;
    @(negedge clk);
    cs_cpu = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_fill_busy", rdy_cpu, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_fill");
    check_lines("rst_fill", 10'h000);
    repeat (70) @(negedge clk);
    check_idle("rst_fill_later");
    check_lines("rst_fill_later", 10'h000);
    $display("txn reset mid-fill addr=1200");

    check("strobe_overlap", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, CPU/SDRAM byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data word width (datapath lives outside this block).
REQ-003 SHALL have a single clock and reset: clk input 1, rising-edge clock; rst input 1, reset that is synchronous and active-high.
REQ-004 SHALL have ports:
- Address_cpu, input, 16: CPU address, split as tag[15:8], index[7:5], offset[4:0].
- DOut_cpu, input, 8: CPU write data, passed through only and unused by the control logic.
- wr_rd_cpu, input, 1: 1 = write, 0 = read.
- cs_cpu, input, 1: request strobe.
- rdy_cpu, output, 1: controller idle and ready.
- Address_sdram, output, 16: SDRAM word address.
- wr_rd_sdram, output, 1: 1 = SDRAM write, 0 = SDRAM read.
- mstrb_sdram, output, 1: SDRAM memory strobe, one cycle per word.
- mux_sel, output, 1: SRAM write-data source, 0 = CPU, 1 = SDRAM.
- demux_sel, output, 1: SRAM read-data destination, 0 = CPU, 1 = SDRAM.
- wen_sram, output, 1: SRAM write enable.
- address_cache_ctrl_sram, output, 8: SRAM address {index, offset}.

Function
REQ-005 SHALL implement a direct-mapped, 8-line, 32-byte-block, write-back, write-allocate cache controller.
REQ-006 SHALL hold metadata in a top-level array cache_line[0:7], each entry 10 bits = {valid[9], dirty[8], tag[7:0]}, readable hierarchically by benches.
REQ-007 SHALL use states IDLE, COMPARE, WRITEBACK, FILL and ACCESS.
REQ-008 IDLE: rdy_cpu=1 and all other outputs 0; when cs_cpu=1, latch Address_cpu and wr_rd_cpu, drive rdy_cpu=0 from the next cycle, and go to COMPARE.
REQ-009 COMPARE, one cycle, against the latched index: hit = valid and tag match -> ACCESS; miss with valid and dirty -> WRITEBACK; otherwise -> FILL.
REQ-010 WRITEBACK SHALL take 2 cycles per word for offsets k = 0..31:
- cycle A: address_cache_ctrl_sram = {index, k}, demux_sel = 1.
- cycle B: Address_sdram = {stored tag, index, k}, wr_rd_sdram = 1, mstrb_sdram = 1.
- after k = 31, go to FILL.
REQ-011 FILL SHALL take 2 cycles per word for offsets k = 0..31:
- cycle A: Address_sdram = {new tag, index, k}, wr_rd_sdram = 0, mstrb_sdram = 1.
- cycle B: address_cache_ctrl_sram = {index, k}, mux_sel = 1, wen_sram = 1.
- after k = 31, set cache_line[index] = {1, 0, new tag} and go to ACCESS.
REQ-012 ACCESS SHALL take one cycle with address_cache_ctrl_sram = {index, offset}:
- write: mux_sel = 0, wen_sram = 1, set dirty = 1.
- read: demux_sel = 0, wen_sram = 0.
- then go to IDLE.
REQ-013 Latency SHALL be 2 cycles after acceptance for a hit, 66 for a clean or invalid miss, and 130 for a dirty miss, measured until rdy_cpu = 1 again.
REQ-014 cs_cpu and CPU inputs SHALL be ignored outside IDLE; the request is latched at acceptance and changes mid-operation have no effect.
REQ-015 cs_cpu still high on return to IDLE SHALL be accepted as a new request; for an unchanged request this is an idempotent hit.
REQ-016 Outputs SHALL be registered; mstrb_sdram and wen_sram SHALL never be high in the same cycle.
REQ-017 A read hit or read miss SHALL never set the dirty bit; a write always leaves the line valid = 1, dirty = 1.

Reset
REQ-018 While rst = 1 at a clk edge:
- state goes to IDLE and all 8 cache_line entries are cleared to 0.
- rdy_cpu = 1; Address_sdram, wr_rd_sdram, mstrb_sdram, mux_sel, demux_sel, wen_sram and address_cache_ctrl_sram = 0.
- any WRITEBACK or FILL in progress is abandoned without a metadata update.

Structure
REQ-019 SHALL place TAG_W = 8, INDEX_W = 3, OFFSET_W = 5, DEPTH = 8, WORDS_PER_BLOCK = 32 and the state enumeration in a shared package cache_pkg.
REQ-020 SHALL use one natural sub-module, cache_word_counter, a 5-bit offset counter with a half-cycle phase bit used by WRITEBACK and FILL; cache_line remains in cache_controller.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Write miss to empty line: reset, then write 0xFFE0 (cs held 4 cycles) -> 32 SDRAM reads at 0xFFE0..0xFFFF, then cache_line[7] = valid 1 / dirty 1 / tag FF, other lines 0.
- Dirty write miss: after the first scenario, write 0x9FE2 -> 32 SDRAM writes at 0xFFE0..0xFFFF, then 32 SDRAM reads at 0x9FE0..0x9FFF, then line 7 = 1/1/9F; rdy_cpu low for 130 cycles.
- Dirty read miss: after the first scenario, read 0x9FE2 -> same write-back and fill, then line 7 = 1/0/9F.
- Read hit: read 0x9FE5 after the dirty read miss -> no mstrb_sdram, address_cache_ctrl_sram = 0xE5, demux_sel = 0, rdy_cpu returns after 2 cycles, metadata unchanged.
- Reset mid-FILL: assert rst during FILL -> next cycle all outputs at reset values, rdy_cpu = 1, all lines 0.
